datamem_responder: RTL and testbench

- Target-side data memory for the CPU data path: accepts one load/store request at a time and returns a response after a fixed access latency.
- Uses a valid/ready handshake on both the request and response channels.
- Storage is a little-endian byte array. Transfer sizes are 1/2/4/8 bytes, matching the CPU's `xfer_size` encoding; loads are zero-extended.
- Sits between the CPU's memory-access stage and the backing array, and replaces the single-cycle combinational memory for multi-cycle CPU work.

---
 rtl/datamem_pkg.sv | 19 +
 rtl/datamem_responder_if.sv | 25 ++
 rtl/datamem_bytearray.sv | 32 +++
 rtl/datamem_responder.sv | 117 +++++++++++
 tb/tb_datamem_responder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/datamem_pkg.sv
// Shared types and helpers for the datamem responder: FSM states and transfer-size encodings.
package datamem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  function automatic logic size_legal(input logic [3:0] size);
    return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
  endfunction

endpackage

// File: rtl/datamem_responder_if.sv
// Request/response bus between the CPU memory stage (master) and the data memory (slave).
interface datamem_responder_if;
  // Both channels: a transfer happens on a rising edge where valid and ready are both 1;
  // the sender holds its payload stable while valid=1 and ready=0.
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/datamem_bytearray.sv
// Little-endian byte array: synchronous multi-byte write port, combinational zero-extended read port.
module datamem_bytearray #(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    size,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  // Caller guarantees addr is aligned and in range whenever a byte lane is enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < size) mem[addr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < size) rdata[8*i +: 8] = mem[addr + AW'(i)];
    end
  end

endmodule

// File: rtl/datamem_responder.sv
// Multi-cycle data memory target: one request at a time, fixed LATENCY busy cycles, held response.
module datamem_responder
  import datamem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                clk,
  input  logic                reset,
  datamem_responder_if.slave  bus,
  output state_t              dbg_state
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          lat_write;
  logic [63:0]   lat_addr;
  logic [3:0]    lat_size;
  logic [63:0]   lat_wdata;
  logic [63:0]   rdata_q;
  logic          err_q;

  logic          access;
  logic          acc_err;
  logic [64:0]   end_addr;
  logic          arr_we;
  logic [63:0]   arr_rdata;

  assign access = (state == BUSY) && (cnt == '0);

  // 65-bit end address so any upper address bit (or wrap) counts as out of range.
  always_comb begin
    end_addr = {1'b0, lat_addr} + 65'(lat_size);
    acc_err  = !size_legal(lat_size)
            || ((lat_addr[3:0] & (lat_size - 4'd1)) != 4'd0)
            || (end_addr > 65'(DEPTH_BYTES));
  end

  // A reset on the commit edge drops the write along with the rest of the access.
  assign arr_we = access && lat_write && !acc_err && !reset;

  datamem_bytearray #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (lat_addr[AW-1:0]),
    .size (lat_size),
    .wdata(lat_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = BUSY;
      BUSY:    if (cnt == '0)     state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_size  <= bus.req_size;
            lat_wdata <= bus.req_wdata;
            cnt       <= CW'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || lat_write) ? 64'h0 : arr_rdata;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_datamem_responder.sv
// Bench for datamem_responder: directed vector table, reset/backpressure sequences, random traffic vs a byte model.
module tb_datamem_responder;
  import datamem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;

  datamem_responder_if bus();

  datamem_responder #(
    .DEPTH_BYTES(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [64:0] exp_q[$];
  logic [7:0]  model[DEPTH];

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [3:0]  size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from a plain byte array; stores update the model only when legal.
  task automatic model_access(input logic wr, input logic [63:0] addr, input logic [3:0] size,
                              input logic [63:0] wdata, output logic [64:0] res);
    logic [63:0] r;
    r = 64'h0;
    if (!(size == 4'd1 || size == 4'd2 || size == 4'd4 || size == 4'd8) ||
        (addr % 64'(size)) != 64'd0 || addr > 64'(DEPTH) - 64'(size)) begin
      res = {1'b1, 64'h0};
    end else begin
      for (int i = 0; i < int'(size); i++) begin
        if (wr) model[int'(addr) + i] = wdata[8*i +: 8];
        else    r[8*i +: 8] = model[int'(addr) + i];
      end
      res = {1'b0, wr ? 64'h0 : r};
    end
  endtask

  // Starts and ends on a falling edge. hold>0 stalls rsp_ready and pulses a stray request.
  task automatic do_txn(input logic wr, input logic [63:0] addr, input logic [3:0] size,
                        input logic [63:0] wdata, input logic [64:0] exp, input int hold);
    int cyc;
    logic [64:0] want;
    exp_q.push_back(exp);
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready_idle", 65'(bus.req_ready), 65'(1));
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_addr  = {$urandom, $urandom};
    bus.req_wdata = {$urandom, $urandom};
    check("req_ready_busy", 65'(bus.req_ready), 65'(0));
    cyc = 1;
    while (!bus.rsp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 65'(cyc), 65'(LAT + 1));
    want = exp_q.pop_front();
    check("rsp", {bus.rsp_err, bus.rsp_rdata}, want);
    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = 1'b0;
      if (h == 1) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = addr;
        bus.req_size  = 4'd8;
        bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("bp_rsp_valid", 65'(bus.rsp_valid), 65'(1));
      check("bp_rsp_hold", {bus.rsp_err, bus.rsp_rdata}, want);
      check("bp_req_ready", 65'(bus.req_ready), 65'(0));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", 65'(bus.rsp_valid), 65'(0));
    check("req_ready_rise", 65'(bus.req_ready), 65'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] e;
    logic [63:0] wd;
    logic [3:0]  sizes[5];
    sizes[0] = 4'd1; sizes[1] = 4'd2; sizes[2] = 4'd4; sizes[3] = 4'd8; sizes[4] = 4'd3;

    vecs[0]  = '{1'b1, 64'd16,   4'd8, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 64'd16,   4'd8, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[2]  = '{1'b0, 64'd17,   4'd1, 64'h0, 64'hCD, 1'b0};
    vecs[3]  = '{1'b1, 64'd16,   4'd1, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0, 1'b0};
    vecs[4]  = '{1'b0, 64'd16,   4'd8, 64'h0, 64'h0123_4567_89AB_CD5A, 1'b0};
    vecs[5]  = '{1'b0, 64'd18,   4'd2, 64'h0, 64'h89AB, 1'b0};
    vecs[6]  = '{1'b0, 64'd20,   4'd4, 64'h0, 64'h0123_4567, 1'b0};
    vecs[7]  = '{1'b0, 64'd6,    4'd4, 64'h0, 64'h0, 1'b1};
    vecs[8]  = '{1'b0, 64'd0,    4'd3, 64'h0, 64'h0, 1'b1};
    vecs[9]  = '{1'b1, 64'd1016, 4'd8, 64'h1122_3344_5566_7788, 64'h0, 1'b0};
    vecs[10] = '{1'b1, 64'd1020, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1};
    vecs[11] = '{1'b0, 64'd1016, 4'd8, 64'h0, 64'h1122_3344_5566_7788, 1'b0};
    vecs[12] = '{1'b1, 64'd1022, 4'd2, 64'h0000_0000_0000_BEEF, 64'h0, 1'b0};
    vecs[13] = '{1'b0, 64'd1016, 4'd8, 64'h0, 64'hBEEF_3344_5566_7788, 1'b0};
    vecs[14] = '{1'b1, 64'd1023, 4'd2, 64'h0000_0000_0000_1234, 64'h0, 1'b1};
    vecs[15] = '{1'b0, 64'd1024, 4'd1, 64'h0, 64'h0, 1'b1};
    vecs[16] = '{1'b0, 64'h8000_0000_0000_0010, 4'd1, 64'h0, 64'h0, 1'b1};
    vecs[17] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 4'd4, 64'h0000_0000_CAFE_F00D, 64'h0, 1'b1};
    vecs[18] = '{1'b0, 64'd1016, 4'd8, 64'h0, 64'hBEEF_3344_5566_7788, 1'b0};
    vecs[19] = '{1'b0, 64'd1023, 4'd1, 64'h0, 64'hBE, 1'b0};
    vecs[20] = '{1'b0, 64'd16,   4'd0, 64'h0, 64'h0, 1'b1};
    vecs[21] = '{1'b1, 64'd16,   4'd8, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = 4'd0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset, with rsp_ready toggling to show it has no effect.
    for (int c = 0; c < 5; c++) begin
      bus.rsp_ready = 1'(c % 2);
      @(negedge clk);
      check("idle_req_ready", 65'(bus.req_ready), 65'(1));
      check("idle_rsp_valid", 65'(bus.rsp_valid), 65'(0));
      check("idle_rsp", {bus.rsp_err, bus.rsp_rdata}, 65'(0));
      check("idle_state", 65'(dbg_state), 65'(IDLE));
    end
    bus.rsp_ready = 1'b0;

    for (int v = 0; v < 22; v++) begin
      do_txn(vecs[v].wr, vecs[v].addr, vecs[v].size, vecs[v].wdata,
             {vecs[v].err, vecs[v].rdata}, 0);
    end

    // Fill bytes 0..63 with known data so the model tracks the array from here on.
    for (int a = 0; a < 64; a += 8) begin
      wd = {$urandom, $urandom};
      model_access(1'b1, 64'(a), 4'd8, wd, e);
      do_txn(1'b1, 64'(a), 4'd8, wd, e, 0);
    end

    // Reset during BUSY of a store: no write, back to IDLE.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 64'd0;
    bus.req_size  = 4'd8;
    bus.req_wdata = 64'hDEAD;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_busy_state", 65'(dbg_state), 65'(BUSY));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy_idle", 65'(dbg_state), 65'(IDLE));
    check("rst_busy_rsp_valid", 65'(bus.rsp_valid), 65'(0));
    check("rst_busy_req_ready", 65'(bus.req_ready), 65'(1));
    model_access(1'b0, 64'd0, 4'd8, 64'h0, e);
    do_txn(1'b0, 64'd0, 4'd8, 64'h0, e, 0);

    // Reset during RESP of a store: response dropped, write stays committed.
    wd = 64'hA5A5_0F0F_1234_5678;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 64'd8;
    bus.req_size  = 4'd8;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 50 && !bus.rsp_valid; c++) @(negedge clk);
    check("rst_resp_reached", 65'(bus.rsp_valid), 65'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_resp_dropped", 65'(bus.rsp_valid), 65'(0));
    check("rst_resp_cleared", {bus.rsp_err, bus.rsp_rdata}, 65'(0));
    model_access(1'b1, 64'd8, 4'd8, wd, e);
    model_access(1'b0, 64'd8, 4'd8, 64'h0, e);
    do_txn(1'b0, 64'd8, 4'd8, 64'h0, e, 0);

    // Backpressure with a stray store pulse, then confirm the stray store was ignored.
    model_access(1'b0, 64'd16, 4'd8, 64'h0, e);
    do_txn(1'b0, 64'd16, 4'd8, 64'h0, e, 4);
    do_txn(1'b0, 64'd16, 4'd8, 64'h0, e, 0);

    for (int n = 0; n < 40; n++) begin
      logic        wr;
      logic [3:0]  sz;
      logic [63:0] ad;
      wr = 1'($urandom_range(0, 1));
      sz = sizes[$urandom_range(0, 4)];
      ad = 64'($urandom_range(0, 63));
      wd = {$urandom, $urandom};
      model_access(wr, ad, sz, wd, e);
      do_txn(wr, ad, sz, wd, e, (n % 7 == 3) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
